// File: rtl/hazard_flush_ctrl.sv
// hazard_flush_ctrl: pipeline hazard and flush controller.
// Handles taken-branch flushes, load-use bubbles, data-memory wait states
// and a sticky memory-timeout fault. Stage-register enables and flush
// requests are combinational from the current state and inputs; the state,
// counters and fault flag are registered.
// Optional build macro HAZARD_PERF_CNT_EN adds saturating StallCount and
// FlushCount outputs.
module hazard_flush_ctrl #(
    parameter int unsigned LU_STALL_CYCLES = 1,
    parameter int unsigned MEM_TIMEOUT     = 15
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [4:0] ID_Rs,
    input  logic [4:0] ID_Rt,
    input  logic       ID_UsesRt,
    input  logic       EX_MemRead,
    input  logic [4:0] EX_WriteReg,
    input  logic [1:0] MEM_BranchType,
    input  logic       MEM_Zero,
    input  logic       MEM_Sign,
    input  logic       MEM_MemRead,
    input  logic       MEM_MemWre,
    input  logic       MemReady,
    output logic       PCWre,
    output logic       IF_ID_Wre,
    output logic       ID_EX_Wre,
    output logic       EX_MEM_Wre,
    output logic       IF_ID_Flush,
    output logic       ID_EX_Flush,
    output logic       EX_MEM_Flush,
    output logic       PCSrcBranch,
    output logic       MemTimeout,
    output logic [1:0] State
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [15:0] StallCount,
    output logic [15:0] FlushCount
`endif
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_LU_STALL = 2'b01,
        ST_MEM_WAIT = 2'b10,
        ST_FAULT    = 2'b11
    } state_e;

    localparam logic [2:0] LU_RELOAD = 3'(LU_STALL_CYCLES - 1);
    // The RUN cycle that detects the busy access already counts as wait
    // cycle 1, so the fault fires once the count of elapsed wait cycles
    // reaches MEM_TIMEOUT-1 inside MEM_WAIT.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_e     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic [2:0] stall_cnt_q, stall_cnt_d;
    logic       mem_timeout_q, mem_timeout_d;

    logic taken;
    logic load_use;
    logic mem_busy;

    // Branch resolution from the flags registered into MEM
    always_comb begin
        taken = 1'b0;
        case (MEM_BranchType)
            2'b01:   taken = MEM_Zero;
            2'b10:   taken = !MEM_Zero;
            2'b11:   taken = MEM_Sign;
            default: taken = 1'b0;
        endcase
    end

    // Hazard detection: load-use against ID sources, and outstanding memory access
    always_comb begin
        load_use = EX_MemRead && (EX_WriteReg != '0) &&
                   ((EX_WriteReg == ID_Rs) || (ID_UsesRt && (EX_WriteReg == ID_Rt)));
        mem_busy = (MEM_MemRead || MEM_MemWre) && !MemReady;
    end

    // Next-state, counter and output decode
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        stall_cnt_d   = stall_cnt_q;
        mem_timeout_d = mem_timeout_q;
        PCWre         = 1'b1;
        IF_ID_Wre     = 1'b1;
        ID_EX_Wre     = 1'b1;
        EX_MEM_Wre    = 1'b1;
        IF_ID_Flush   = 1'b0;
        ID_EX_Flush   = 1'b0;
        EX_MEM_Flush  = 1'b0;
        PCSrcBranch   = 1'b0;

        if (Reset) begin
            state_d       = ST_RUN;
            wait_cnt_d    = '0;
            stall_cnt_d   = '0;
            mem_timeout_d = 1'b0;
            PCWre         = 1'b0;
            IF_ID_Wre     = 1'b0;
            ID_EX_Wre     = 1'b0;
            EX_MEM_Wre    = 1'b0;
            IF_ID_Flush   = 1'b1;
            ID_EX_Flush   = 1'b1;
            EX_MEM_Flush  = 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (taken) begin
                        PCSrcBranch  = 1'b1;
                        IF_ID_Flush  = 1'b1;
                        ID_EX_Flush  = 1'b1;
                        EX_MEM_Flush = 1'b1;
                    end else if (mem_busy) begin
                        PCWre      = 1'b0;
                        IF_ID_Wre  = 1'b0;
                        ID_EX_Wre  = 1'b0;
                        EX_MEM_Wre = 1'b0;
                        wait_cnt_d = 8'd1;
                        state_d    = ST_MEM_WAIT;
                    end else if (load_use) begin
                        PCWre       = 1'b0;
                        IF_ID_Wre   = 1'b0;
                        ID_EX_Flush = 1'b1;
                        stall_cnt_d = LU_RELOAD;
                        if (LU_STALL_CYCLES > 1) begin
                            state_d = ST_LU_STALL;
                        end
                    end
                end
                ST_LU_STALL: begin
                    PCWre       = 1'b0;
                    IF_ID_Wre   = 1'b0;
                    ID_EX_Flush = 1'b1;
                    if (stall_cnt_q <= 3'd1) begin
                        stall_cnt_d = '0;
                        state_d     = ST_RUN;
                    end else begin
                        stall_cnt_d = stall_cnt_q - 3'd1;
                    end
                end
                ST_MEM_WAIT: begin
                    if (mem_busy) begin
                        PCWre      = 1'b0;
                        IF_ID_Wre  = 1'b0;
                        ID_EX_Wre  = 1'b0;
                        EX_MEM_Wre = 1'b0;
                        if (wait_cnt_q >= WAIT_LAST) begin
                            state_d       = ST_FAULT;
                            mem_timeout_d = 1'b1;
                        end else begin
                            wait_cnt_d = wait_cnt_q + 8'd1;
                        end
                    end else begin
                        wait_cnt_d = '0;
                        state_d    = ST_RUN;
                    end
                end
                ST_FAULT: begin
                    PCWre         = 1'b0;
                    IF_ID_Wre     = 1'b0;
                    ID_EX_Wre     = 1'b0;
                    EX_MEM_Wre    = 1'b0;
                    mem_timeout_d = 1'b1;
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // State, counters and fault flag registers
    always_ff @(posedge Clk) begin
        state_q       <= state_d;
        wait_cnt_q    <= wait_cnt_d;
        stall_cnt_q   <= stall_cnt_d;
        mem_timeout_q <= mem_timeout_d;
    end

    assign State      = state_q;
    assign MemTimeout = mem_timeout_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_count_q, stall_count_d;
    logic [15:0] flush_count_q, flush_count_d;

    // Saturating performance counters for stall and taken-branch cycles
    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (Reset) begin
            stall_count_d = '0;
            flush_count_d = '0;
        end else begin
            if (!PCWre && (stall_count_q != '1)) begin
                stall_count_d = stall_count_q + 16'd1;
            end
            if (taken && (flush_count_q != '1)) begin
                flush_count_d = flush_count_q + 16'd1;
            end
        end
    end

    // Performance counter registers
    always_ff @(posedge Clk) begin
        stall_count_q <= stall_count_d;
        flush_count_q <= flush_count_d;
    end

    assign StallCount = stall_count_q;
    assign FlushCount = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Directed bench for hazard_flush_ctrl with LU_STALL_CYCLES=2, MEM_TIMEOUT=4.
// Observed vector: {PCWre, IF_ID_Wre, ID_EX_Wre, EX_MEM_Wre,
//                   IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush,
//                   PCSrcBranch, MemTimeout, State[1:0]}
module tb_hazard_flush_ctrl;

    logic       Clk;
    logic       Reset;
    logic [4:0] ID_Rs;
    logic [4:0] ID_Rt;
    logic       ID_UsesRt;
    logic       EX_MemRead;
    logic [4:0] EX_WriteReg;
    logic [1:0] MEM_BranchType;
    logic       MEM_Zero;
    logic       MEM_Sign;
    logic       MEM_MemRead;
    logic       MEM_MemWre;
    logic       MemReady;
    logic       PCWre;
    logic       IF_ID_Wre;
    logic       ID_EX_Wre;
    logic       EX_MEM_Wre;
    logic       IF_ID_Flush;
    logic       ID_EX_Flush;
    logic       EX_MEM_Flush;
    logic       PCSrcBranch;
    logic       MemTimeout;
    logic [1:0] State;

    int checks = 0;
    int errors = 0;

    logic [10:0] exp_q[$];
    string       tag_q[$];

    localparam logic [10:0] IDLE    = 11'b1111_000_0_0_00;
    localparam logic [10:0] BR      = 11'b1111_111_1_0_00;
    localparam logic [10:0] MW_RUN  = 11'b0000_000_0_0_00;
    localparam logic [10:0] MW      = 11'b0000_000_0_0_10;
    localparam logic [10:0] MW_DONE = 11'b1111_000_0_0_10;
    localparam logic [10:0] LU_RUN  = 11'b0011_010_0_0_00;
    localparam logic [10:0] LU_ST   = 11'b0011_010_0_0_01;
    localparam logic [10:0] FAULT   = 11'b0000_000_0_1_11;
    localparam logic [10:0] RST_00  = 11'b0000_111_0_0_00;
    localparam logic [10:0] RST_01  = 11'b0000_111_0_0_01;
    localparam logic [10:0] RST_10  = 11'b0000_111_0_0_10;
    localparam logic [10:0] RST_F   = 11'b0000_111_0_1_11;

    hazard_flush_ctrl #(
        .LU_STALL_CYCLES(2),
        .MEM_TIMEOUT    (4)
    ) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .ID_Rs         (ID_Rs),
        .ID_Rt         (ID_Rt),
        .ID_UsesRt     (ID_UsesRt),
        .EX_MemRead    (EX_MemRead),
        .EX_WriteReg   (EX_WriteReg),
        .MEM_BranchType(MEM_BranchType),
        .MEM_Zero      (MEM_Zero),
        .MEM_Sign      (MEM_Sign),
        .MEM_MemRead   (MEM_MemRead),
        .MEM_MemWre    (MEM_MemWre),
        .MemReady      (MemReady),
        .PCWre         (PCWre),
        .IF_ID_Wre     (IF_ID_Wre),
        .ID_EX_Wre     (ID_EX_Wre),
        .EX_MEM_Wre    (EX_MEM_Wre),
        .IF_ID_Flush   (IF_ID_Flush),
        .ID_EX_Flush   (ID_EX_Flush),
        .EX_MEM_Flush  (EX_MEM_Flush),
        .PCSrcBranch   (PCSrcBranch),
        .MemTimeout    (MemTimeout),
        .State         (State)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Return all non-reset inputs to a quiet pipeline
    task automatic clr();
        ID_Rs          = '0;
        ID_Rt          = '0;
        ID_UsesRt      = 1'b0;
        EX_MemRead     = 1'b0;
        EX_WriteReg    = '0;
        MEM_BranchType = 2'b00;
        MEM_Zero       = 1'b0;
        MEM_Sign       = 1'b0;
        MEM_MemRead    = 1'b0;
        MEM_MemWre     = 1'b0;
        MemReady       = 1'b0;
    endtask

    // Queue the expectation for the inputs just driven, compare at the falling edge,
    // then advance past the next rising edge
    task automatic step(input string tag, input logic [10:0] exp);
        logic [10:0] obs;
        logic [10:0] e;
        string       t;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(negedge Clk);
        obs = {PCWre, IF_ID_Wre, ID_EX_Wre, EX_MEM_Wre,
               IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush,
               PCSrcBranch, MemTimeout, State};
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", t, obs, e);
        end
        @(posedge Clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        clr();
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        step("reset", RST_00);
        Reset = 1'b0;
        step("idle", IDLE);

        // Branch resolution for each type
        clr(); MEM_BranchType = 2'b01; MEM_Zero = 1'b1; step("beq_taken", BR);
        clr(); MEM_BranchType = 2'b01; MEM_Zero = 1'b0; step("beq_not_taken", IDLE);
        clr(); MEM_BranchType = 2'b10; MEM_Zero = 1'b0; step("bne_taken", BR);
        clr(); MEM_BranchType = 2'b10; MEM_Zero = 1'b1; step("bne_not_taken", IDLE);
        clr(); MEM_BranchType = 2'b11; MEM_Sign = 1'b1; step("bltz_taken", BR);
        clr(); MEM_BranchType = 2'b00; MEM_Zero = 1'b1; MEM_Sign = 1'b1; step("none_type", IDLE);

        // Load-use on Rs: two bubble cycles, then RUN
        clr(); EX_MemRead = 1'b1; EX_WriteReg = 5'd5; ID_Rs = 5'd5;
        step("lu_rs_c1", LU_RUN);
        step("lu_rs_c2", LU_ST);
        clr(); step("lu_rs_done", IDLE);

        // Load-use on Rt only when Rt is read
        clr(); EX_MemRead = 1'b1; EX_WriteReg = 5'd7; ID_Rt = 5'd7; ID_UsesRt = 1'b1; ID_Rs = 5'd3;
        step("lu_rt_c1", LU_RUN);
        clr(); step("lu_rt_c2", LU_ST);
        clr(); step("lu_rt_done", IDLE);
        clr(); EX_MemRead = 1'b1; EX_WriteReg = 5'd7; ID_Rt = 5'd7; ID_UsesRt = 1'b0; ID_Rs = 5'd3;
        step("lu_rt_unused", IDLE);
        clr(); EX_MemRead = 1'b0; EX_WriteReg = 5'd9; ID_Rs = 5'd9;
        step("no_load_match", IDLE);

        // Register 0 never creates a hazard
        clr(); EX_MemRead = 1'b1; EX_WriteReg = 5'd0; ID_Rt = 5'd0; ID_Rs = 5'd0; ID_UsesRt = 1'b1;
        step("reg0_exempt", IDLE);

        // Memory wait: three busy cycles then ready
        clr(); MEM_MemRead = 1'b1; MemReady = 1'b0;
        step("mw_c1", MW_RUN);
        step("mw_c2", MW);
        step("mw_c3", MW);
        MemReady = 1'b1; step("mw_ready", MW_DONE);
        clr(); step("mw_done", IDLE);
        clr(); MEM_MemWre = 1'b1; MemReady = 1'b1; step("store_ready", IDLE);

        // Coincident events: Taken wins, then MemBusy over LoadUse
        clr(); MEM_BranchType = 2'b01; MEM_Zero = 1'b1; MEM_MemRead = 1'b1;
        EX_MemRead = 1'b1; EX_WriteReg = 5'd4; ID_Rs = 5'd4;
        step("all_events", BR);
        clr(); MEM_MemRead = 1'b1; EX_MemRead = 1'b1; EX_WriteReg = 5'd4; ID_Rs = 5'd4;
        step("busy_over_lu", MW_RUN);
        clr(); MEM_MemRead = 1'b1; MemReady = 1'b1; step("busy_lu_ready", MW_DONE);
        clr(); step("busy_lu_done", IDLE);

        // Reset during LU_STALL aborts the stall
        clr(); EX_MemRead = 1'b1; EX_WriteReg = 5'd12; ID_Rs = 5'd12;
        step("lu_pre_reset", LU_RUN);
        Reset = 1'b1; step("reset_in_stall", RST_01);
        Reset = 1'b0; clr(); step("after_stall_reset", IDLE);
        clr(); EX_MemRead = 1'b1; EX_WriteReg = 5'd12; ID_Rs = 5'd12;
        step("lu_again_c1", LU_RUN);
        clr(); step("lu_again_c2", LU_ST);
        clr(); step("lu_again_done", IDLE);

        // Reset during MEM_WAIT, then a full timeout
        clr(); MEM_MemRead = 1'b1; step("mw2_c1", MW_RUN);
        step("mw2_c2", MW);
        Reset = 1'b1; step("reset_in_wait", RST_10);
        Reset = 1'b0; step("to_c1", MW_RUN);
        step("to_c2", MW);
        step("to_c3", MW);
        step("to_c4", MW);
        step("fault", FAULT);
        MemReady = 1'b1; step("fault_hold_ready", FAULT);
        clr(); MEM_BranchType = 2'b01; MEM_Zero = 1'b1; step("fault_hold_branch", FAULT);
        clr(); step("fault_hold_idle", FAULT);
        Reset = 1'b1; step("reset_in_fault", RST_F);
        step("reset_cleared", RST_00);
        Reset = 1'b0; step("post_fault_idle", IDLE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
